// File: rtl/stage0_preif_if.sv
// Instruction SRAM request bus between the pre-IF stage (master) and instruction memory (slave).
interface stage0_preif_if;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;

   modport master (
      output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
             inst_sram_addr, inst_sram_wdata,
      input  inst_sram_addr_ok
   );

   modport slave (
      input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
             inst_sram_addr, inst_sram_wdata,
      output inst_sram_addr_ok
   );
endinterface

// File: rtl/stage0_preif.sv
// Pre-IF stage: owns the fetch PC, selects the next fetch address (sequential, branch,
// buffered branch) and issues it to instruction memory, tagging wrong-path fetches for IF.
module stage0_preif #(
   parameter logic [31:0] RESET_PC     = 32'h1C000000,
   parameter int          WIDTH_BR_BUS = 34
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    fs_allow_in,
   input  logic [WIDTH_BR_BUS-1:0] br_bus,
   output logic                    to_fs_valid,
   output logic [31:0]             to_fs_pc,
   output logic                    to_fs_drop,
   stage0_preif_if.master          inst_sram
);

   logic        br_stall;
   logic        br_taken;
   logic [31:0] br_target;

   logic [31:0] pf_pc_q,           pf_pc_d;
   logic        req_lock_q,        req_lock_d;
   logic [31:0] lock_addr_q,       lock_addr_d;
   logic        br_buf_valid_q,    br_buf_valid_d;
   logic [31:0] br_buf_target_q,   br_buf_target_d;
   logic        drop_pending_q,    drop_pending_d;

   logic        req_new;
   logic        sram_req;
   logic [31:0] sram_addr;
   logic        hs;
   logic        drop;
   logic        from_buf;

   assign br_stall  = br_bus[WIDTH_BR_BUS-1];
   assign br_taken  = br_bus[WIDTH_BR_BUS-2];
   assign br_target = br_bus[31:0];

   always_comb begin
      req_new  = !reset && fs_allow_in && !br_stall;
      sram_req = req_lock_q || req_new;

      if (req_lock_q)
         sram_addr = lock_addr_q;
      else if (br_taken)
         sram_addr = br_target;
      else if (br_buf_valid_q)
         sram_addr = br_buf_target_q;
      else
         sram_addr = pf_pc_q;

      hs       = sram_req && inst_sram.inst_sram_addr_ok;
      drop     = hs && (drop_pending_q || (req_lock_q && br_taken));
      from_buf = !req_lock_q && !br_taken && br_buf_valid_q;
   end

   always_comb begin
      pf_pc_d         = pf_pc_q;
      req_lock_d      = req_lock_q;
      lock_addr_d     = lock_addr_q;
      br_buf_valid_d  = br_buf_valid_q;
      br_buf_target_d = br_buf_target_q;
      drop_pending_d  = drop_pending_q;

      if (reset) begin
         pf_pc_d        = RESET_PC;
         req_lock_d     = 1'b0;
         br_buf_valid_d = 1'b0;
         drop_pending_d = 1'b0;
      end else begin
         if (hs) begin
            req_lock_d     = 1'b0;
            drop_pending_d = 1'b0;
            if (!drop)
               pf_pc_d = sram_addr + 32'd4;
         end else if (sram_req && !req_lock_q) begin
            req_lock_d  = 1'b1;
            lock_addr_d = sram_addr;
         end

         // A redirect is consumed the moment a request carrying it goes out (accepted or
         // locked); otherwise it waits in the buffer and any locked fetch becomes wrong-path.
         if (br_taken) begin
            if (req_lock_q || !sram_req) begin
               br_buf_valid_d  = 1'b1;
               br_buf_target_d = br_target;
               if (req_lock_q && !hs)
                  drop_pending_d = 1'b1;
            end else begin
               br_buf_valid_d = 1'b0;
            end
         end else if (sram_req && from_buf) begin
            br_buf_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      pf_pc_q         <= pf_pc_d;
      req_lock_q      <= req_lock_d;
      lock_addr_q     <= lock_addr_d;
      br_buf_valid_q  <= br_buf_valid_d;
      br_buf_target_q <= br_buf_target_d;
      drop_pending_q  <= drop_pending_d;
   end

   assign inst_sram.inst_sram_req   = sram_req;
   assign inst_sram.inst_sram_addr  = sram_addr;
   assign inst_sram.inst_sram_wr    = 1'b0;
   assign inst_sram.inst_sram_size  = 2'b10;
   assign inst_sram.inst_sram_wstrb = 4'b0000;
   assign inst_sram.inst_sram_wdata = 32'd0;

   assign to_fs_valid = hs;
   assign to_fs_pc    = sram_addr;
   assign to_fs_drop  = drop;

endmodule
